// File: rtl/mem_stream_pkg.sv
// Shared types and default widths for the memory burst stream master.
package mem_stream_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned LEN_W_DEF   = 16;
  localparam int unsigned MEM_LAT_DEF = 2;
  localparam int unsigned WAIT_CNT_W  = 4;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    REQ,
    WAIT,
    DELIVER,
    GAP,
    DONE
  } state_e;

endpackage

// File: rtl/mem_stream_wait_ctr.sv
// Decides when the WAIT phase of a memory access ends: on the responder's done
// flag when DONE_HANDSHAKE_EN is defined, otherwise after MEM_LAT fixed cycles.
module mem_stream_wait_ctr
  import mem_stream_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
  input  logic clk,
  input  logic RST,
  input  logic in_wait,
  input  logic dir,
  input  logic mem_done_rd,
  input  logic mem_done_wr,
  output logic wait_exit_c
);

`ifdef DONE_HANDSHAKE_EN

  // Only the flag matching the access direction can end the wait.
  assign wait_exit_c = in_wait && ((dir == DIR_WRITE) ? mem_done_wr : mem_done_rd);

  logic unused_cfg;
  assign unused_cfg = ^{clk, RST, WAIT_CNT_W'(MEM_LAT)};

`else

  logic [WAIT_CNT_W-1:0] cnt;

  // Counts completed WAIT cycles; the last one is cnt == MEM_LAT-1.
  always_ff @(posedge clk) begin
    if (RST) begin
      cnt <= '0;
    end else if (!in_wait || wait_exit_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + WAIT_CNT_W'(1);
    end
  end

  assign wait_exit_c = in_wait && (cnt == WAIT_CNT_W'(MEM_LAT - 1));

  logic unused_done;
  assign unused_done = ^{dir, mem_done_rd, mem_done_wr};

`endif

endmodule

// File: rtl/mem_stream_master.sv
// Burst master moving words between a word-addressed memory and a valid/ready
// stream. WAIT exit source is selected by the DONE_HANDSHAKE_EN macro.
module mem_stream_master
  import mem_stream_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done_rd,
  input  logic              mem_done_wr,
  output logic              busy,
  output logic              burst_done,
  output logic [LEN_W-1:0]  words_left
);

  state_e            state;
  state_e            state_d;
  logic              dir_q;
  logic              dir_d;
  logic [ADDR_W-1:0] addr_d;
  logic [LEN_W-1:0]  len_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] rdata_d;
  logic              wait_exit_c;

  mem_stream_wait_ctr #(
    .MEM_LAT (MEM_LAT)
  ) u_wait_ctr (
    .clk         (clk),
    .RST         (RST),
    .in_wait     (state == WAIT),
    .dir         (dir_q),
    .mem_done_rd (mem_done_rd),
    .mem_done_wr (mem_done_wr),
    .wait_exit_c (wait_exit_c)
  );

  // Next state and next values of the datapath registers.
  always_comb begin
    state_d = state;
    dir_d   = dir_q;
    addr_d  = mem_addr;
    len_d   = words_left;
    wdata_d = mem_wdata;
    rdata_d = out_data;
    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          dir_d  = cmd_dir;
          addr_d = cmd_addr;
          len_d  = cmd_len;
          if (cmd_len == '0) begin
            state_d = DONE;
          end else if (cmd_dir == DIR_WRITE) begin
            state_d = FETCH;
          end else begin
            state_d = REQ;
          end
        end
      end
      FETCH: begin
        if (in_valid && in_ready) begin
          wdata_d = in_data;
          state_d = REQ;
        end
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_exit_c) begin
          if (dir_q == DIR_READ) begin
            rdata_d = mem_rdata;
            state_d = DELIVER;
          end else begin
            state_d = GAP;
          end
        end
      end
      DELIVER: begin
        if (out_valid && out_ready) begin
          state_d = GAP;
        end
      end
      GAP: begin
        // Strobes are low here so the responder can drop its done flag.
        addr_d = mem_addr + ADDR_W'(1);
        len_d  = words_left - LEN_W'(1);
        if (words_left == LEN_W'(1)) begin
          state_d = DONE;
        end else if (dir_q == DIR_WRITE) begin
          state_d = FETCH;
        end else begin
          state_d = REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; every output is registered off the next state.
  always_ff @(posedge clk) begin
    if (RST) begin
      state      <= IDLE;
      dir_q      <= DIR_READ;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      burst_done <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      in_ready   <= 1'b0;
      words_left <= '0;
    end else begin
      state      <= state_d;
      dir_q      <= dir_d;
      cmd_ready  <= (state_d == IDLE);
      busy       <= (state_d != IDLE);
      burst_done <= (state_d == DONE);
      mem_rd     <= ((state_d == REQ) || (state_d == WAIT)) && (dir_d == DIR_READ);
      mem_wr     <= ((state_d == REQ) || (state_d == WAIT)) && (dir_d == DIR_WRITE);
      mem_addr   <= addr_d;
      mem_wdata  <= wdata_d;
      out_valid  <= (state_d == DELIVER);
      out_data   <= rdata_d;
      in_ready   <= (state_d == FETCH);
      words_left <= len_d;
    end
  end

endmodule

// File: doc/mem_stream_master.md
Name: mem_stream_master

Overview:
- Initiator side of the word-addressed memory read/write handshake. The memory block is the responder; this block drives address, read/write strobes and data, and consumes the done flags.
- Accepts one burst command (direction, start address, length) and moves words between memory and a valid/ready stream.
- Feeds the DCNN IO path: loads image/weight tiles out of memory, and writes result tiles back into it.

Parameters:
- ADDR_W, 16, memory address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 16, memory and stream word width.
- LEN_W, 16, burst length counter width.
- MEM_LAT, 2, fixed wait cycles per access when DONE_HANDSHAKE_EN is not defined; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- RST  in  1  reset, synchronous, active-high
- cmd_valid  in  1  burst command offered
- cmd_ready  out  1  high only in IDLE
- cmd_dir  in  1  0 = memory->stream (read), 1 = stream->memory (write)
- cmd_addr  in  ADDR_W  first word address
- cmd_len  in  LEN_W  number of words
- out_valid  out  1  read word available
- out_data  out  DATA_W  read word
- out_ready  in  1  consumer accepts
- in_valid  in  1  write word offered
- in_data  in  DATA_W  write word
- in_ready  out  1  master accepts
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  write data
- mem_rd  out  1  read strobe (read_signal)
- mem_wr  out  1  write strobe (write_signal)
- mem_rdata  in  DATA_W  read data (dataout)
- mem_done_rd  in  1  read complete (doneRead)
- mem_done_wr  in  1  write complete (doneWrite)
- busy  out  1  not in IDLE
- burst_done  out  1  one-cycle pulse when a burst finishes
- words_left  out  LEN_W  remaining words

Behaviour:
- Reset: RST sampled high at posedge forces state IDLE and clears all outputs (mem_*, out_*, in_ready, busy, burst_done, words_left) to 0; cmd_ready = 1 from the following cycle. A reset mid-burst aborts the burst with no done pulse. Any half-issued memory access is dropped; strobes are low the cycle after reset.
- States: IDLE, FETCH (write only), REQ, WAIT, DELIVER (read only), GAP, DONE.
- IDLE: cmd_ready = 1. cmd_valid & cmd_ready latches dir, addr and len.
  - len = 0: go to DONE, no memory access.
  - len > 0: read goes to REQ; write goes to FETCH.
- FETCH: in_ready = 1; on in_valid, capture in_data into mem_wdata and go to REQ.
- REQ: lasts 1 cycle; mem_addr valid; mem_rd (read) or mem_wr (write) = 1.
- WAIT: the strobe stays high; mem_addr and mem_wdata stay stable.
  - Exit on the first posedge sampling the matching done flag = 1.
  - On a read exit, mem_rdata is captured into out_data.
  - The non-matching done flag is ignored.
- DELIVER: out_valid = 1 and out_data held until out_ready. Do not drop valid without a handshake.
- GAP: 1 cycle with both strobes low; required between accesses so the responder can clear done. Then addr += 1 (wrap), words_left -= 1.
  - words_left = 0: go to DONE.
  - Otherwise read goes to REQ and write goes to FETCH.
- DONE: burst_done = 1 for 1 cycle, then IDLE.
- mem_rd and mem_wr are never high together. cmd_valid while busy is ignored.
- Minimum read cost per word, with 1-cycle done and out_ready held high: REQ 1 + WAIT 1 + DELIVER 1 + GAP 1 = 4 cycles.

Optional Feature:
- Macro DONE_HANDSHAKE_EN.
- Defined: WAIT exits on mem_done_rd / mem_done_wr as above.
- Undefined: done inputs are ignored; WAIT lasts exactly MEM_LAT cycles (4-bit counter), and read data is sampled on the last WAIT cycle.

Decomposition:
- Package mem_stream_pkg holds:
  - state enum (IDLE, FETCH, REQ, WAIT, DELIVER, GAP, DONE);
  - DIR_READ = 0, DIR_WRITE = 1;
  - default widths.
- One sub-module: mem_stream_wait_ctr, the WAIT exit logic (done compare or MEM_LAT counter). It is the only piece affected by the macro.

Test Plan:
- Read burst, addr 0x0010, len 4, memory preloaded 0xA0..0xA3, out_ready = 1 → out_data 0xA0, 0xA1, 0xA2, 0xA3 in order; addresses 0x10–0x13; one burst_done pulse; busy low the cycle after.
- Write burst, addr 0x0100, len 3, in_data 0x1111/0x2222/0x3333 with in_valid gaps → memory holds those at 0x100–0x102; mem_wr never overlaps mem_rd; at least one strobe-low cycle between accesses.
- Backpressure: read len 2, out_ready low 5 cycles on word 0 → out_valid and out_data stable throughout; no second mem_rd until word 0 is accepted.
- Wrap and zero length:
  - addr 0xFFFF, len 2 → accesses 0xFFFF then 0x0000.
  - len 0 → burst_done 2 cycles after the command, no strobes.
- Reset mid-burst: RST during WAIT of word 2 of 4 → next cycle all outputs 0, no burst_done; a new command then completes normally.
- Macro off, MEM_LAT = 3: done inputs tied 0 → each access holds its strobe for REQ + 3 WAIT cycles; the burst completes.
